data_cache_sa: RTL and testbench
================================

Name: data_cache_sa

Overview:
- Parametrised N-way set-associative, write-through, read-allocate data cache; successor of the single-way direct-mapped cache.
- Sits between the load/store requester and the DRAM controller.
- Adds a valid/ready request handshake, a miss FSM with a held memory request, and per-set round-robin replacement.

Parameters:
INDEX_COUNT, 256, sets; power of two, >= 2
WAYS, 2, ways per set; power of two, 1..8
DATA_W, 11, data word width
TAG_W, 20, tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  cache accepts a request (high only in IDLE)
req_we  in  1  1 = write, 0 = read
req_index  in  $clog2(INDEX_COUNT)  set select
req_tag  in  TAG_W  request tag
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DATA_W  read data (0 on writes)
resp_hit  out  1  1 = hit, 0 = miss
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = write-through, 0 = line fill
mem_index  out  $clog2(INDEX_COUNT)  memory set address
mem_tag  out  TAG_W  memory tag address
mem_wdata  out  DATA_W  write-through data
mem_ready  in  1  memory completes the current request this cycle
mem_rdata  in  DATA_W  fill data, valid with mem_ready on reads

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Storage per way/set: {valid, tag, data}.
- Reset clears all valid bits and round-robin pointers.
- Outputs after reset: state IDLE, req_ready=1, and resp_valid, resp_rdata, resp_hit, mem_req, mem_we, mem_index, mem_tag, mem_wdata all 0.
- States: IDLE, LOOKUP, MEM_WAIT, RESP.
- IDLE: req_valid&req_ready latches req_* into registers -> LOOKUP. req_ready is low in every other state.
- LOOKUP:
  - Compare the latched tag against all ways of the set. Hit = valid & tag match; at most one way matches (invariant).
  - Read hit: capture the way data -> RESP.
  - Write hit: update the way data in this cycle -> MEM_WAIT with mem_we=1.
  - Write miss: no allocate -> MEM_WAIT with mem_we=1.
  - Read miss: -> MEM_WAIT with mem_we=0.
- MEM_WAIT:
  - mem_req=1, and mem_* stay stable until the cycle mem_ready=1; mem_ready may arrive in the first MEM_WAIT cycle.
  - On mem_ready with a read: fill the victim way with {1, tag, mem_rdata}, capture mem_rdata -> RESP.
  - On mem_ready with a write: -> RESP.
  - mem_ready outside MEM_WAIT is ignored.
- Victim selection: lowest-numbered invalid way; if all ways are valid, the way at the set's round-robin pointer. The pointer increments mod WAYS only on a fill that evicts a valid line.
- RESP: resp_valid=1 for exactly one cycle with resp_hit and resp_rdata -> IDLE.
- Latency:
  - Read hit: resp_valid 2 cycles after the accept edge.
  - Read miss and all writes: 2 cycles plus MEM_WAIT cycles after the accept edge.
- One request is outstanding at a time; there is no back-to-back acceptance.
- Reset mid-operation: returns to IDLE next edge; mem_req drops; an in-flight fill is discarded; no partial line write.
- WAYS=1 degenerates to direct-mapped; the round-robin pointer is constant 0.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined:
  - Adds output ports hit_cnt[31:0] and miss_cnt[31:0].
  - Each counter increments once per request, in the RESP cycle, according to resp_hit.
  - Counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dcache_pkg:
  - State enum dcache_state_e {IDLE, LOOKUP, MEM_WAIT, RESP}.
  - Line struct template for {valid, tag, data}.
  - Constant localparam PERF_CNT_W=32.
- Sub-module dcache_victim_sel: combinational; inputs are the way valid vector and the round-robin pointer; output is the victim way index.

Test Plan:
- Read index 5, tag 0x12345 after reset -> read miss, mem_req=1 with mem_we=0. mem_ready after 3 cycles with mem_rdata=0x2AB -> resp_valid, resp_hit=0, resp_rdata=0x2AB. Repeating the same read -> resp_hit=1, data 0x2AB, 2-cycle latency.
- Write hit to index 5, tag 0x12345, wdata 0x155 -> mem_we=1, mem_wdata=0x155, resp_hit=1. Next read of the same address -> hit with 0x155.
- Write miss to index 7, tag 0x00001 -> write-through issued, resp_hit=0. Read of the same address -> miss (no allocate).
- WAYS=2, index 3: fill tags A, B, then C. C evicts way 0 (pointer 0 -> 1). Read A -> miss; its fill evicts way 1 (B). Read C -> hit.
- mem_ready held high before the request -> no effect. mem_ready in the first MEM_WAIT cycle -> RESP next cycle.
- rst asserted in MEM_WAIT -> mem_req=0 next cycle and the line stays invalid. Perf macro on: hit_cnt/miss_cnt match expected totals and read 0 after reset.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the set-associative data cache
// Purpose: FSM state encoding, line layout template and counter width used by
//          data_cache_sa and its victim selector.
// Ports:   none (package).
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } dcache_state_e;

  localparam int PERF_CNT_W = 32;

  // Line layout at the default widths. The cache body stores the three fields
  // in separate arrays so that only the valid bits need a reset path.
  localparam int LINE_TAG_W  = 20;
  localparam int LINE_DATA_W = 11;

  typedef struct packed {
    logic                   valid;
    logic [LINE_TAG_W-1:0]  tag;
    logic [LINE_DATA_W-1:0] data;
  } dcache_line_t;

endpackage

// File: rtl/dcache_victim_sel.sv
// rtl/dcache_victim_sel.sv - combinational victim way selection for one set
// Purpose: pick the lowest-numbered invalid way; if every way is valid, pick
//          the way at the set's round-robin pointer.
// Ports:   i_valid     - valid bit of each way in the set
//          i_rr_ptr    - round-robin pointer of the set
//          o_victim    - way index to fill
//          o_all_valid - every way valid, so the fill evicts a live line
module dcache_victim_sel #(
  parameter int WAYS  = 2,
  parameter int WAY_W = 1
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_rr_ptr,
  output logic [WAY_W-1:0] o_victim,
  output logic             o_all_valid
);

  always_comb begin
    o_victim    = i_rr_ptr;
    o_all_valid = &i_valid;
    // Descending scan: the last assignment wins, leaving the lowest invalid way.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) o_victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/data_cache_sa.sv
// rtl/data_cache_sa.sv - N-way set-associative write-through read-allocate data cache
// Purpose: single-outstanding cache between a load/store requester and DRAM.
//          IDLE accepts, LOOKUP compares all ways, MEM_WAIT holds a memory
//          request until mem_ready, RESP strobes the response for one cycle.
// Ports:   clk, rst (sync, active-high)
//          req_valid/req_ready/req_we/req_index/req_tag/req_wdata - request
//          resp_valid/resp_rdata/resp_hit                         - response
//          mem_req/mem_we/mem_index/mem_tag/mem_wdata              - memory request
//          mem_ready/mem_rdata                                     - memory completion
//          hit_cnt/miss_cnt - saturating counters, only with DCACHE_PERF_CNT_EN defined
module data_cache_sa
  import dcache_pkg::*;
#(
  parameter int INDEX_COUNT = 256,
  parameter int WAYS        = 2,
  parameter int DATA_W      = 11,
  parameter int TAG_W       = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [$clog2(INDEX_COUNT)-1:0] req_index,
  input  logic [TAG_W-1:0]               req_tag,
  input  logic [DATA_W-1:0]              req_wdata,
  output logic                           resp_valid,
  output logic [DATA_W-1:0]              resp_rdata,
  output logic                           resp_hit,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [$clog2(INDEX_COUNT)-1:0] mem_index,
  output logic [TAG_W-1:0]               mem_tag,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_ready,
  input  logic [DATA_W-1:0]              mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]          hit_cnt,
  output logic [PERF_CNT_W-1:0]          miss_cnt
`endif
);

  localparam int IDX_W = $clog2(INDEX_COUNT);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]   r_valid [INDEX_COUNT];
  logic [TAG_W-1:0]  r_tags  [INDEX_COUNT][WAYS];
  logic [DATA_W-1:0] r_data  [INDEX_COUNT][WAYS];
  logic [WAY_W-1:0]  r_rr    [INDEX_COUNT];

  dcache_state_e     r_state;
  logic              r_we;
  logic [IDX_W-1:0]  r_index;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_wdata;
  logic              r_hit;

  logic [WAYS-1:0]   w_set_valid;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [DATA_W-1:0] w_hit_data;
  logic [WAY_W-1:0]  w_victim;
  logic              w_all_valid;
  logic              w_fill;
  logic              w_wr_hit;

  assign w_set_valid = r_valid[r_index];

  // At most one way matches, so the scan order does not matter.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_set_valid[w] && (r_tags[r_index][w] == r_tag)) begin
        w_hit      = 1'b1;
        w_hit_way  = WAY_W'(w);
        w_hit_data = r_data[r_index][w];
      end
    end
  end

  dcache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .i_valid     (w_set_valid),
    .i_rr_ptr    (r_rr[r_index]),
    .o_victim    (w_victim),
    .o_all_valid (w_all_valid)
  );

  assign w_fill   = (r_state == MEM_WAIT) && mem_ready && !r_we;
  assign w_wr_hit = (r_state == LOOKUP) && r_we && w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_hit   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_index  <= '0;
      mem_tag    <= '0;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      r_index    <= '0;
      r_tag      <= '0;
      r_wdata    <= '0;
      r_hit      <= 1'b0;
      for (int i = 0; i < INDEX_COUNT; i++) begin
        r_valid[i] <= '0;
        r_rr[i]    <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            r_we      <= req_we;
            r_index   <= req_index;
            r_tag     <= req_tag;
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            r_state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!r_we && w_hit) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_rdata <= w_hit_data;
            r_state    <= RESP;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= r_we;
            mem_index <= r_index;
            mem_tag   <= r_tag;
            mem_wdata <= r_we ? r_wdata : '0;
            r_hit     <= w_hit;
            r_state   <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_hit   <= r_hit;
            resp_rdata <= r_we ? '0 : mem_rdata;
            if (!r_we) begin
              r_valid[r_index][w_victim] <= 1'b1;
              // The pointer only advances when a live line is evicted.
              if (w_all_valid) begin
                r_rr[r_index] <= (r_rr[r_index] == WAY_W'(WAYS - 1)) ? '0
                                 : r_rr[r_index] + 1'b1;
              end
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; a line is only live through its valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_wr_hit) r_data[r_index][w_hit_way] <= r_wdata;
      if (w_fill) begin
        r_tags[r_index][w_victim] <= r_tag;
        r_data[r_index][w_victim] <= mem_rdata;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (r_state == RESP) begin
      if (resp_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_sa.sv
// tb/tb_data_cache_sa.sv - scoreboard testbench for data_cache_sa
module tb_data_cache_sa;

  localparam int IC = 256;
  localparam int WAYS = 2;
  localparam int DW = 11;
  localparam int TW = 20;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [IW-1:0] req_index = '0;
  logic [TW-1:0] req_tag = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_hit;
  logic          mem_req;
  logic          mem_we;
  logic [IW-1:0] mem_index;
  logic [TW-1:0] mem_tag;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  data_cache_sa #(
    .INDEX_COUNT (IC),
    .WAYS        (WAYS),
    .DATA_W      (DW),
    .TAG_W       (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_index  (req_index),
    .req_tag    (req_tag),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_index  (mem_index),
    .mem_tag    (mem_tag),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: per-set lines, round-robin pointers, backing memory.
  logic          mv  [IC][WAYS];
  logic [TW-1:0] mt  [IC][WAYS];
  logic [DW-1:0] md  [IC][WAYS];
  int            mrr [IC];
  logic [DW-1:0] backing [logic [IW+TW-1:0]];

  typedef struct {
    logic          hit;
    logic [DW-1:0] rdata;
    int            lat;
  } resp_t;

  typedef struct {
    logic          we;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            d;
  } memt_t;

  resp_t exp_q[$];
  memt_t mem_q[$];
  int    last_accept = 0;
  int    resp_count = 0;
  int    exp_hits = 0;
  int    exp_misses = 0;
  bit    mem_pause = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < IC; i++) begin
      mrr[i] = 0;
      for (int w = 0; w < WAYS; w++) mv[i][w] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] backing_get(input logic [IW+TW-1:0] key);
    if (!backing.exists(key)) backing[key] = DW'($urandom);
    return backing[key];
  endfunction

  task automatic issue(input logic we, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                       input logic [DW-1:0] wdata, input int d);
    resp_t e;
    memt_t m;
    logic hit;
    int hw, v, start, n;
    logic [IW+TW-1:0] key;
    hit = 1'b0;
    hw = 0;
    key = {idx, tag};
    for (int w = 0; w < WAYS; w++)
      if (mv[idx][w] && mt[idx][w] == tag) begin hit = 1'b1; hw = w; end
    e.hit = hit;
    m.we = we; m.idx = idx; m.tag = tag; m.wdata = wdata; m.d = d; m.rdata = '0;
    if (!we && hit) begin
      e.rdata = md[idx][hw];
      e.lat = 2;
    end else if (!we) begin
      m.rdata = backing_get(key);
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!mv[idx][w] && v < 0) v = w;
      if (v < 0) begin
        v = mrr[idx];
        mrr[idx] = (mrr[idx] + 1) % WAYS;
      end
      mv[idx][v] = 1'b1;
      mt[idx][v] = tag;
      md[idx][v] = m.rdata;
      e.rdata = m.rdata;
      e.lat = 3 + d;
      mem_q.push_back(m);
    end else begin
      if (hit) md[idx][hw] = wdata;
      backing[key] = wdata;
      e.rdata = '0;
      e.lat = 3 + d;
      mem_q.push_back(m);
    end
    exp_q.push_back(e);

    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_before_issue", req_ready, 1'b1);
    start = resp_count;
    req_valid = 1'b1; req_we = we; req_index = idx; req_tag = tag; req_wdata = wdata;
    @(negedge clk);
    last_accept = cyc;
    req_valid = 1'b0;
    check("req_ready_low_after_accept", req_ready, 1'b0);
    n = 0;
    while (resp_count == start && n < 60) begin @(negedge clk); n++; end
    check("resp_arrived", 64'(resp_count - start), 64'd1);
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (resp_valid) begin
      resp_t e;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp actual=resp_valid expected=idle");
      end else begin
        e = exp_q.pop_front();
        check("resp_hit", resp_hit, e.hit);
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_latency", 64'(cyc - last_accept + 1), 64'(e.lat));
        if (e.hit) exp_hits++; else exp_misses++;
      end
      resp_count++;
    end
  end

  // Memory responder: checks the request and its stability, then completes it.
  initial begin
    memt_t t;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_pause && !rst) begin
        if (mem_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_mem_req actual=mem_req expected=none");
        end else begin
          t = mem_q.pop_front();
          check("mem_we", mem_we, t.we);
          check("mem_addr", {mem_index, mem_tag}, {t.idx, t.tag});
          if (t.we) check("mem_wdata", mem_wdata, t.wdata);
          for (int j = 0; j < t.d; j++) begin
            @(negedge clk);
            check("mem_stable", {mem_req, mem_we, mem_index, mem_tag},
                  {1'b1, t.we, t.idx, t.tag});
          end
          mem_ready = 1'b1;
          mem_rdata = t.rdata;
          @(negedge clk);
          mem_ready = 1'b0;
          mem_rdata = DW'($urandom);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp", {resp_valid, resp_hit, resp_rdata}, '0);
    check("rst_mem", {mem_req, mem_we, mem_index, mem_tag, mem_wdata}, '0);

    // Directed read miss then hit.
    backing[{8'd5, 20'h12345}] = 11'h2AB;
    issue(1'b0, 8'd5, 20'h12345, '0, 2);
    issue(1'b0, 8'd5, 20'h12345, '0, 0);
    // Write hit then read.
    issue(1'b1, 8'd5, 20'h12345, 11'h155, 1);
    issue(1'b0, 8'd5, 20'h12345, '0, 0);
    // Write miss, no allocate.
    issue(1'b1, 8'd7, 20'h00001, 11'h0F0, 0);
    issue(1'b0, 8'd7, 20'h00001, '0, 0);
    // Round-robin eviction in set 3.
    issue(1'b0, 8'd3, 20'h0000A, '0, 0);
    issue(1'b0, 8'd3, 20'h0000B, '0, 1);
    issue(1'b0, 8'd3, 20'h0000C, '0, 0);
    issue(1'b0, 8'd3, 20'h0000A, '0, 3);
    issue(1'b0, 8'd3, 20'h0000C, '0, 0);

    // mem_ready while idle is ignored.
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 11'h7FF;
    repeat (3) begin
      @(negedge clk);
      check("idle_mem_ready_no_resp", {resp_valid, mem_req, req_ready}, 3'b001);
    end
    mem_ready = 1'b0;
    issue(1'b0, 8'd3, 20'h0000C, '0, 0);

    // Reset during MEM_WAIT discards the fill.
    mem_pause = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_index = 8'd9; req_tag = 20'h00777;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 5) begin @(negedge clk); n++; end
    check("mid_mem_req", mem_req, 1'b1);
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 11'h5A5;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_ready", {req_ready, resp_valid}, 2'b10);
    mem_pause = 1'b0;
    model_reset();
    exp_hits = 0;
    exp_misses = 0;
`ifdef DCACHE_PERF_CNT_EN
    check("cnt_after_rst", {hit_cnt, miss_cnt}, '0);
`endif
    issue(1'b0, 8'd9, 20'h00777, '0, 0);
    issue(1'b0, 8'd5, 20'h12345, '0, 0);

    // Randomized traffic on a few sets and tags to force hits and evictions.
    for (int k = 0; k < 200; k++) begin
      issue(($urandom_range(0, 3) == 0), IW'($urandom_range(0, 3)),
            TW'($urandom_range(0, 5)), DW'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
`ifdef DCACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 64'(exp_hits));
    check("miss_cnt", miss_cnt, 64'(exp_misses));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
